// File: rtl/alu_pipe_arbiter.sv
// alu_pipe_arbiter
//   Two requesters share one two-stage ALU pipeline. A round-robin arbiter
//   grants at most one operation per cycle. The result comes back two edges
//   after the transfer, tagged with the requester that issued it.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   reqK_valid/func/a/b (K=0,1)     operation request; func is one-hot
//   reqK_ready                      combinational grant; transfer = valid & ready
//   rspK_valid                      one-cycle pulse, result belongs to requester K
//   rsp_x, rsp_carry, rsp_parity    shared response bus; holds between pulses
//   rsp_err                         func was not one-hot (x/carry forced 0, parity 1)
//   issue_cnt                       accepted-operation counter, wraps
module alu_pipe_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [7:0]       req0_func,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_func,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    output logic             req1_ready,
    output logic             rsp0_valid,
    output logic             rsp1_valid,
    output logic [3:0]       rsp_x,
    output logic             rsp_carry,
    output logic             rsp_parity,
    output logic             rsp_err,
    output logic [CNT_W-1:0] issue_cnt
);

    localparam int STAGES = 2;

    // Opcode is the bit position of the one-hot func code.
    localparam logic [2:0] OP_ADD  = 3'd7;
    localparam logic [2:0] OP_SUB  = 3'd6;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_XNOR = 3'd0;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       tag;
        logic       err;
    } s1_t;

    typedef struct packed {
        logic [3:0] x;
        logic       carry;
        logic       parity;
        logic       err;
        logic       tag;
    } s2_t;

    function automatic logic [2:0] func_op(input logic [7:0] f);
        logic [2:0] op;
        op = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (f[i]) op = 3'(i);
        end
        return op;
    endfunction

    // Zero or more than one bit set.
    function automatic logic func_bad(input logic [7:0] f);
        return (f == 8'd0) || ((f & (f - 8'd1)) != 8'd0);
    endfunction

    logic              last;
    logic              xfer;
    logic [STAGES:1]   vld_pipe;
    s1_t               s1_d, s1_q;
    s2_t               s2_d, s2_q;
    logic [4:0]        wide;

    // ---------------- arbitration ----------------
    // last==1 means requester 1 was served most recently, so 0 wins a tie.
    assign req0_ready = req0_valid & (~req1_valid | last);
    assign req1_ready = req1_valid & (~req0_valid | ~last);
    assign xfer       = req0_ready | req1_ready;

    always_comb begin
        s1_d = '0;
        if (req1_ready) begin
            s1_d.op  = func_op(req1_func);
            s1_d.a   = req1_a;
            s1_d.b   = req1_b;
            s1_d.tag = 1'b1;
            s1_d.err = func_bad(req1_func);
        end else begin
            s1_d.op  = func_op(req0_func);
            s1_d.a   = req0_a;
            s1_d.b   = req0_b;
            s1_d.tag = 1'b0;
            s1_d.err = func_bad(req0_func);
        end
    end

    // ---------------- ALU (between stage 1 and stage 2) ----------------
    always_comb begin
        wide = '0;
        case (s1_q.op)
            OP_ADD:  wide = {1'b0, s1_q.a} + {1'b0, s1_q.b};
            OP_SUB:  wide = {1'b0, s1_q.a} - {1'b0, s1_q.b};  // bit4 = borrow
            OP_XOR:  wide = {1'b0, s1_q.a ^ s1_q.b};
            OP_OR:   wide = {1'b0, s1_q.a | s1_q.b};
            OP_AND:  wide = {1'b0, s1_q.a & s1_q.b};
            OP_NOR:  wide = {1'b0, ~(s1_q.a | s1_q.b)};
            OP_NAND: wide = {1'b0, ~(s1_q.a & s1_q.b)};
            OP_XNOR: wide = {1'b0, ~(s1_q.a ^ s1_q.b)};
            default: wide = '0;
        endcase

        s2_d.x      = s1_q.err ? 4'd0 : wide[3:0];
        s2_d.carry  = s1_q.err ? 1'b0 : wide[4];
        s2_d.parity = ~^s2_d.x;
        s2_d.err    = s1_q.err;
        s2_d.tag    = s1_q.tag;
    end

    // ---------------- sequential state ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last      <= 1'b1;
            vld_pipe  <= '0;
            s1_q      <= '0;
            s2_q      <= '{x: 4'd0, carry: 1'b0, parity: 1'b1, err: 1'b0, tag: 1'b0};
            issue_cnt <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], xfer};
            if (xfer) begin
                last      <= req1_ready;
                s1_q      <= s1_d;
                issue_cnt <= issue_cnt + 1'b1;
            end
            // Response bus only moves when a result lands; otherwise it holds.
            if (vld_pipe[1]) s2_q <= s2_d;
        end
    end

    assign rsp0_valid = vld_pipe[STAGES] & ~s2_q.tag;
    assign rsp1_valid = vld_pipe[STAGES] &  s2_q.tag;
    assign rsp_x      = s2_q.x;
    assign rsp_carry  = s2_q.carry;
    assign rsp_parity = s2_q.parity;
    assign rsp_err    = s2_q.err;

endmodule

// File: tb/tb_alu_pipe_arbiter.sv
module tb_alu_pipe_arbiter;

    localparam int CNT_W = 2;

    localparam logic [7:0] ADD  = 8'h80;
    localparam logic [7:0] SUB  = 8'h40;
    localparam logic [7:0] XOR_ = 8'h20;
    localparam logic [7:0] OR_  = 8'h10;
    localparam logic [7:0] AND_ = 8'h08;
    localparam logic [7:0] NOR_ = 8'h04;
    localparam logic [7:0] NAND_= 8'h02;
    localparam logic [7:0] XNOR_= 8'h01;

    logic             clk, rst_n;
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0]       req0_func, req1_func;
    logic [3:0]       req0_a, req0_b, req1_a, req1_b;
    logic             rsp0_valid, rsp1_valid, rsp_carry, rsp_parity, rsp_err;
    logic [3:0]       rsp_x;
    logic [CNT_W-1:0] issue_cnt;

    alu_pipe_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_func(req0_func), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_func(req1_func), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_x(rsp_x), .rsp_carry(rsp_carry), .rsp_parity(rsp_parity), .rsp_err(rsp_err),
        .issue_cnt(issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         tag;
        logic [3:0] x;
        logic       c, p, e;
        int         due;
    } exp_t;

    exp_t             q[$];
    int               total  = 0;
    int               passed = 0;
    int               cyc    = 0;
    logic [CNT_W-1:0] exp_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    function automatic exp_t mk(input logic [3:0] x, input logic c, input logic p, input logic e);
        exp_t r;
        r.tag = 1'b0; r.x = x; r.c = c; r.p = p; r.e = e; r.due = 0;
        return r;
    endfunction

    // Monitor: pops the scoreboard whenever a response pulse is seen.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rsp_during_reset", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        end else if (rsp0_valid || rsp1_valid) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_tag",     {30'd0, rsp1_valid, rsp0_valid}, e.tag ? 32'd2 : 32'd1);
                chk("rsp_x",       32'(rsp_x), 32'(e.x));
                chk("rsp_carry",   32'(rsp_carry), 32'(e.c));
                chk("rsp_parity",  32'(rsp_parity), 32'(e.p));
                chk("rsp_err",     32'(rsp_err), 32'(e.e));
                chk("rsp_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    // One cycle of stimulus: called just after a rising edge; checks grants
    // mid-cycle, queues the expected responses, then checks the counter.
    task automatic step(input bit v0, input logic [7:0] f0, input logic [3:0] a0, input logic [3:0] b0,
                        input bit v1, input logic [7:0] f1, input logic [3:0] a1, input logic [3:0] b1,
                        input bit g0, input bit g1, input exp_t e0, input exp_t e1, input bit keep);
        exp_t t;
        req0_valid = v0; req0_func = f0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_func = f1; req1_a = a1; req1_b = b1;
        @(negedge clk);
        chk("ready0", 32'(req0_ready), 32'(g0));
        chk("ready1", 32'(req1_ready), 32'(g1));
        if (g0 && keep) begin t = e0; t.tag = 1'b0; t.due = cyc + 2; q.push_back(t); end
        if (g1 && keep) begin t = e1; t.tag = 1'b1; t.due = cyc + 2; q.push_back(t); end
        if (g0 || g1) exp_cnt++;
        @(posedge clk); #1;
        chk("issue_cnt", 32'(issue_cnt), 32'(exp_cnt));
    endtask

    task automatic idle();
        step(0, 8'h00, 4'h0, 4'h0, 0, 8'h00, 4'h0, 4'h0, 0, 0, mk(0,0,0,0), mk(0,0,0,0), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        exp_t nil;
        nil = mk(0,0,0,0);
        rst_n = 1'b0; exp_cnt = '0;
        req0_valid = 0; req0_func = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_func = 0; req1_a = 0; req1_b = 0;

        #13;
        chk("reset_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("reset_x",      32'(rsp_x), 32'd0);
        chk("reset_carry",  32'(rsp_carry), 32'd0);
        chk("reset_parity", 32'(rsp_parity), 32'd1);
        chk("reset_err",    32'(rsp_err), 32'd0);
        chk("reset_cnt",    32'(issue_cnt), 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Single-requester ops, back-to-back on requester 1.
        step(1, ADD, 4'h5, 4'hE, 0, 8'h00, 4'h0, 4'h0, 1, 0, mk(4'h3,1,1,0), nil, 1);
        step(0, 8'h00, 4'h0, 4'h0, 1, SUB,  4'h5, 4'hE, 0, 1, nil, mk(4'h7,1,0,0), 1);
        step(0, 8'h00, 4'h0, 4'h0, 1, XOR_, 4'h5, 4'hE, 0, 1, nil, mk(4'hB,0,0,0), 1);
        idle();
        idle();
        @(negedge clk);
        chk("hold_x",      32'(rsp_x), 32'hB);
        chk("hold_parity", 32'(rsp_parity), 32'd0);
        chk("hold_valid",  {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        @(posedge clk); #1;

        // Continuous contention: grants alternate starting with requester 0.
        step(1, OR_,   4'hA, 4'h5, 1, AND_,  4'hC, 4'hA, 1, 0, mk(4'hF,0,1,0), nil, 1);
        step(1, NOR_,  4'h3, 4'h5, 1, AND_,  4'hC, 4'hA, 0, 1, nil, mk(4'h8,0,0,0), 1);
        step(1, NOR_,  4'h3, 4'h5, 1, NAND_, 4'hF, 4'hF, 1, 0, mk(4'h8,0,0,0), nil, 1);
        step(1, XNOR_, 4'h9, 4'h6, 1, NAND_, 4'hF, 4'hF, 0, 1, nil, mk(4'h0,0,1,0), 1);
        step(1, XNOR_, 4'h9, 4'h6, 1, ADD,   4'hF, 4'h1, 1, 0, mk(4'h0,0,1,0), nil, 1);
        step(0, 8'h00, 4'h0, 4'h0, 1, ADD,   4'hF, 4'h1, 0, 1, nil, mk(4'h0,1,1,0), 1);

        // Invalid function codes are still accepted and answered with err.
        step(1, 8'h00, 4'hF, 4'hF, 0, 8'h00, 4'h0, 4'h0, 1, 0, mk(4'h0,0,1,1), nil, 1);
        step(0, 8'h00, 4'h0, 4'h0, 1, 8'h81, 4'hF, 4'h1, 0, 1, nil, mk(4'h0,0,1,1), 1);

        // Reset with an operation in flight: it must vanish.
        step(1, ADD, 4'h1, 4'h1, 0, 8'h00, 4'h0, 4'h0, 1, 0, mk(4'h2,0,0,0), nil, 1);
        idle();
        idle();
        step(1, SUB, 4'h1, 4'h1, 0, 8'h00, 4'h0, 4'h0, 1, 0, nil, nil, 0);
        req0_valid = 0; req1_valid = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid",  {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
        chk("rst_mid_cnt",    32'(issue_cnt), 32'd0);
        chk("rst_mid_x",      32'(rsp_x), 32'd0);
        chk("rst_mid_parity", 32'(rsp_parity), 32'd1);
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        step(1, AND_, 4'hF, 4'h3, 1, OR_, 4'h0, 4'h0, 1, 0, mk(4'h3,0,1,0), nil, 1);
        step(0, 8'h00, 4'h0, 4'h0, 1, OR_, 4'h0, 4'h0, 0, 1, nil, mk(4'h0,0,1,0), 1);
        req0_valid = 0; req1_valid = 0;

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
